// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_STEP   = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer that parks a returned instruction while the IF/ID slot is stalled.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        invalidate,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    logic        valid_r;
    logic [31:0] pc_r;
    logic [31:0] instr_r;

    // Buffer register: invalidate beats load, load beats drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            pc_r    <= 32'h0000_0000;
            instr_r <= NOP_INSTR;
        end else if (invalidate) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            pc_r    <= load_pc;
            instr_r <= load_instr;
        end else if (drain) begin
            valid_r <= 1'b0;
        end
    end

    assign valid = valid_r;
    assign pc    = pc_r;
    assign instr = instr_r;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: owns the PC, issues single-outstanding imem requests, fills IF/ID, handles redirects.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_instr,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic        misalign_err
);

    fetch_state_e state_r, state_nxt_s;
    logic [31:0]  pc_r;
    logic [31:0]  req_pc_r;
    logic         slot_valid_r;
    logic [31:0]  slot_pc_r;
    logic [31:0]  slot_instr_r;
    logic         misalign_r;
    logic         req_valid_s;
    logic         req_fire_s;
    logic         buf_valid_s;
    logic [31:0]  buf_pc_s;
    logic [31:0]  buf_instr_s;

    // Request strobe; a WAIT-state follow-on request is withheld on redirect so it never goes wrong-path.
    always_comb begin
        req_valid_s = 1'b0;
        case (state_r)
            FETCH:   req_valid_s = 1'b1;
            WAIT:    req_valid_s = imem_rsp_valid && !stall && !redirect_valid;
            default: req_valid_s = 1'b0;
        endcase
    end

    assign imem_req_valid = req_valid_s && rst_n;
    assign imem_req_addr  = pc_r;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign flush_if_id    = redirect_valid && rst_n;
    assign flush_id_ex    = redirect_valid && rst_n;

    // Next-state selection; a redirect goes to DRAIN whenever a request is left in flight.
    always_comb begin
        state_nxt_s = state_r;
        if (redirect_valid) begin
            case (state_r)
                FETCH:   state_nxt_s = req_fire_s ? DRAIN : FETCH;
                WAIT:    state_nxt_s = imem_rsp_valid ? FETCH : DRAIN;
                HOLD:    state_nxt_s = FETCH;
                DRAIN:   state_nxt_s = imem_rsp_valid ? FETCH : DRAIN;
                default: state_nxt_s = FETCH;
            endcase
        end else begin
            case (state_r)
                FETCH:   state_nxt_s = req_fire_s ? WAIT : FETCH;
                WAIT: begin
                    if (!imem_rsp_valid) begin
                        state_nxt_s = WAIT;
                    end else if (stall) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = req_fire_s ? WAIT : FETCH;
                    end
                end
                HOLD:    state_nxt_s = stall ? HOLD : FETCH;
                DRAIN:   state_nxt_s = imem_rsp_valid ? FETCH : DRAIN;
                default: state_nxt_s = FETCH;
            endcase
        end
    end

    // State, PC and sticky misalignment flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FETCH;
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            misalign_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (req_fire_s) begin
                req_pc_r <= pc_r;
            end
            if (redirect_valid) begin
                pc_r <= align_word(redirect_target);
            end else if (req_fire_s) begin
                pc_r <= pc_r + PC_STEP;
            end
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_r <= 1'b1;
            end
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state_r == WAIT && imem_rsp_valid && stall && !redirect_valid),
        .drain      (state_r == HOLD && !stall && !redirect_valid),
        .invalidate (redirect_valid),
        .load_pc    (req_pc_r),
        .load_instr (imem_rsp_instr),
        .valid      (buf_valid_s),
        .pc         (buf_pc_s),
        .instr      (buf_instr_s)
    );

    // IF/ID slot: holds under stall, otherwise takes a fresh instruction or empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_valid_r <= 1'b0;
            slot_pc_r    <= 32'h0000_0000;
            slot_instr_r <= NOP_INSTR;
        end else if (redirect_valid) begin
            slot_valid_r <= 1'b0;
        end else if (!stall) begin
            if (state_r == WAIT && imem_rsp_valid) begin
                slot_valid_r <= 1'b1;
                slot_pc_r    <= req_pc_r;
                slot_instr_r <= imem_rsp_instr;
            end else if (state_r == HOLD) begin
                slot_valid_r <= buf_valid_s;
                slot_pc_r    <= buf_pc_s;
                slot_instr_r <= buf_instr_s;
            end else begin
                slot_valid_r <= 1'b0;
            end
        end
    end

    assign if_id_valid  = slot_valid_r;
    assign if_id_pc     = slot_pc_r;
    assign if_id_instr  = slot_instr_r;
    assign misalign_err = misalign_r;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: a behavioural imem plus a scoreboard of expected IF/ID deliveries.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_instr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_err;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic        stall_q = 1'b0;

    // Memory model: single outstanding request, latency lat cycles, instruction = ~address.
    logic        mem_ready = 1'b0;
    int          lat = 1;
    logic        pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    int          cnt = 0;

    assign imem_req_ready = mem_ready;
    assign imem_rsp_valid = pend && (cnt == 0);
    assign imem_rsp_instr = imem_rsp_valid ? ~pend_addr : 32'h0;

    fetch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .stall           (stall),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_instr  (imem_rsp_instr),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        stall_q <= stall;
        if (!rst_n) begin
            pend <= 1'b0;
        end else begin
            if (pend && cnt == 0) pend <= 1'b0;
            else if (pend) cnt <= cnt - 1;
            if (imem_req_valid && imem_req_ready) begin
                pend      <= 1'b1;
                pend_addr <= imem_req_addr;
                cnt       <= lat - 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a valid slot after a non-stalled cycle is a fresh delivery.
    always @(negedge clk) begin
        if (rst_n && if_id_valid && !stall_q) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got pc %h expected no delivery", if_id_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", if_id_pc, e);
                check("sb_instr", if_id_instr, ~e);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset state; a redirect during reset must not flush or set misalign_err.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0003;
        tick();
        tick();
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_flush_if_id", {31'd0, flush_if_id}, 32'd0);
        check("rst_flush_id_ex", {31'd0, flush_id_ex}, 32'd0);
        check("rst_if_id_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_if_id_instr", if_id_instr, 32'h0000_0013);
        check("rst_misalign", {31'd0, misalign_err}, 32'd0);
        redirect_valid = 1'b0;
        mem_ready = 1'b1;
        lat = 1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);

        // Peak rate with a 1-cycle memory.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("p1_req_valid0", {31'd0, imem_req_valid}, 32'd1);
        check("p1_addr0", imem_req_addr, 32'h0);
        tick();
        check("p1_addr4", imem_req_addr, 32'h4);
        tick();
        check("p1_addr8", imem_req_addr, 32'h8);
        check("p1_slot0", if_id_pc, 32'h0);
        tick();
        check("p1_slot4_valid", {31'd0, if_id_valid}, 32'd1);
        check("p1_slot4", if_id_pc, 32'h4);
        mem_ready = 1'b0;
        tick();
        check("p1_slot8", if_id_pc, 32'h8);
        check("p1_hold_addr12", imem_req_addr, 32'hC);
        tick();
        check("p1_slot_empty", {31'd0, if_id_valid}, 32'd0);

        // Redirect in WAIT with the response still in flight: DRAIN drops it.
        mem_ready = 1'b1;
        lat = 2;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        check("p2_flush_if_id", {31'd0, flush_if_id}, 32'd1);
        check("p2_flush_id_ex", {31'd0, flush_id_ex}, 32'd1);
        check("p2_noreq_wait", {31'd0, imem_req_valid}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p2_drain_noreq", {31'd0, imem_req_valid}, 32'd0);
        check("p2_drain_noflush", {31'd0, flush_if_id}, 32'd0);
        tick();
        check("p2_target_req", {31'd0, imem_req_valid}, 32'd1);
        check("p2_target_addr", imem_req_addr, 32'h100);
        check("p2_slot_empty", {31'd0, if_id_valid}, 32'd0);
        exp_q.push_back(32'h100);
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        check("p2_next_addr", imem_req_addr, 32'h104);

        // Redirect coinciding with a response in WAIT: no DRAIN, target requested next cycle.
        mem_ready = 1'b1;
        lat = 1;
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0100;
        #1;
        check("p3_noreq", {31'd0, imem_req_valid}, 32'd0);
        check("p3_flush", {31'd0, flush_if_id}, 32'd1);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p3_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("p3_req_addr", imem_req_addr, 32'h100);
        check("p3_dropped", {31'd0, if_id_valid}, 32'd0);
        mem_ready = 1'b0;

        // Stall held three cycles while a response arrives.
        tick();
        mem_ready = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        tick();
        tick();
        stall = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("p4_slot_first", if_id_pc, 32'h100);
        check("p4_noreq_stall", {31'd0, imem_req_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("p4_hold_pc", if_id_pc, 32'h100);
            check("p4_hold_valid", {31'd0, if_id_valid}, 32'd1);
            check("p4_hold_noreq", {31'd0, imem_req_valid}, 32'd0);
        end
        stall = 1'b0;
        tick();
        check("p4_buf_pc", if_id_pc, 32'h104);
        check("p4_buf_instr", if_id_instr, ~32'h104);
        check("p4_resume_addr", imem_req_addr, 32'h108);

        // Misaligned redirect: fetch aligned down, sticky error.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        #1;
        check("p5_misalign_pre", {31'd0, misalign_err}, 32'd0);
        tick();
        check("p5_addr", imem_req_addr, 32'h200);
        check("p5_misalign", {31'd0, misalign_err}, 32'd1);
        redirect_target = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p5_addr_aligned", imem_req_addr, 32'h300);
        check("p5_misalign_sticky", {31'd0, misalign_err}, 32'd1);

        // PC wrap at the top of the address space.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("p6_top_addr", imem_req_addr, 32'hFFFF_FFFC);
        mem_ready = 1'b1;
        lat = 1;
        exp_q.push_back(32'hFFFF_FFFC);
        tick();
        check("p6_wrap_valid", {31'd0, imem_req_valid}, 32'd1);
        check("p6_wrap_addr", imem_req_addr, 32'h0);
        mem_ready = 1'b0;
        tick();
        check("p6_fetch_addr", imem_req_addr, 32'h0);
        mem_ready = 1'b1;
        lat = 2;

        // Reset pulse while a request is outstanding.
        tick();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("p6_rst_noreq", {31'd0, imem_req_valid}, 32'd0);
        check("p6_rst_slot", {31'd0, if_id_valid}, 32'd0);
        check("p6_rst_misalign", {31'd0, misalign_err}, 32'd0);
        check("p6_rst_instr", if_id_instr, 32'h0000_0013);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("p6_post_req", {31'd0, imem_req_valid}, 32'd1);
        check("p6_post_addr", imem_req_addr, 32'h0);
        tick();
        check("p6_post_slot", {31'd0, if_id_valid}, 32'd0);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch front end that consumes the branch/jump resolution produced in EX (`takebranch`, target address) and acts on it. Owns the PC register, issues single-outstanding requests to instruction memory over a valid/ready request and valid response interface, and delivers fetched instructions into the IF/ID slot. On a redirect it squashes wrong-path work and restarts fetch at the target.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `redirect_valid`  in  1  branch/jump taken in EX (`takebranch`).
- `redirect_target`  in  32  target address (`JalAddr` / branch target).
- `stall`  in  1  hazard-unit stall; IF/ID slot must hold.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  fetch address, word aligned.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_rsp_valid`  in  1  instruction returned; at most one per accepted request, at least 1 cycle after acceptance.
- `imem_rsp_instr`  in  32  returned instruction.
- `if_id_valid`  out  1  IF/ID slot holds a live instruction.
- `if_id_pc`  out  32  PC of slot instruction.
- `if_id_instr`  out  32  slot instruction.
- `flush_if_id`  out  1  squash IF/ID at this edge.
- `flush_id_ex`  out  1  squash ID/EX at this edge.
- `misalign_err`  out  1  sticky: a redirect target had `[1:0] != 0`.

## Operation
- FSM states: FETCH (request presented), WAIT (one request outstanding), HOLD (response buffered, slot blocked by stall), DRAIN (outstanding response is wrong-path, discard).
- FETCH: `imem_req_valid`=1, addr=`pc`. On handshake: latch `req_pc`=`pc`, `pc`+=4, go WAIT.
- WAIT: on `imem_rsp_valid` with `!stall`, load slot {1, `req_pc`, instr}. In that same cycle, `imem_req_valid`=1 at `pc`; on handshake stay WAIT, otherwise go FETCH. On `imem_rsp_valid` with `stall`, capture into hold buffer and go HOLD.
- HOLD: no requests. When `!stall`, move buffer into slot and go FETCH.
- Slot: holds its contents while `stall`=1. When `stall`=0 and no new instruction loads, `if_id_valid` clears.
- Redirect (priority over stall and every other event):
  - `flush_if_id` = `flush_id_ex` = `redirect_valid`, combinational, forced 0 while `rst_n`=0.
  - At the edge: `pc` ← {`redirect_target[31:2]`, 2'b00}; `if_id_valid` ← 0; hold buffer is invalidated.
  - Next state is DRAIN if a request is still outstanding after this cycle: WAIT with no response this cycle, or a FETCH/WAIT request handshake in the same cycle.
  - Otherwise next state is FETCH, covering HOLD, WAIT with a response this cycle (response dropped), and FETCH with no handshake.
- DRAIN: `imem_req_valid`=0. The next `imem_rsp_valid` is dropped, then go FETCH. A redirect in DRAIN only updates `pc`; it stays DRAIN unless the response arrives in the same cycle, in which case go FETCH.
- `imem_req_addr` may change while unaccepted only on the cycle after a redirect.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- `misalign_err` is set on any redirect with `target[1:0] != 0` and cleared only by reset.

## Timing
- Reset values: state FETCH, `pc`=`RESET_PC`, `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=32'h0000_0013 (NOP), `misalign_err`=0.
- `imem_req_valid`=0 while `rst_n`=0. It is 1 in the first cycle after release.
- Reset asserted mid-operation abandons any outstanding request. Memory must not return a response for it after reset release.
- Latency: response cycle → `if_id_valid` at the next edge.
- Peak rate: 1 instruction/cycle with an always-ready, 1-cycle memory.
- Redirect penalty: redirect cycle → target request presented on the next cycle.

## Structure
- `fetch_pkg`: `fetch_state_e` (FETCH, WAIT, HOLD, DRAIN), `NOP_INSTR`=32'h0000_0013, `PC_STEP`=4.
- Sub-module `fetch_hold_buf`: a one-entry {valid, pc, instr} register with load, drain and invalidate controls.
- The FSM and PC logic stay in the top module.

## Test plan
- Reset release with memory always ready and 1-cycle latency → requests at 0x0, 0x4, 0x8 on consecutive cycles; slot shows PC 0x0, 0x4, 0x8 back-to-back.
- Redirect to 0x100 in WAIT, response arriving the cycle after → flushes high in the redirect cycle; the late response is dropped via DRAIN; next slot PC is 0x100.
- Redirect in the same cycle as a response in WAIT → response dropped; request 0x100 presented next cycle; no DRAIN.
- `stall` held 3 cycles while a response arrives → HOLD; slot keeps its old PC; buffered instruction appears in the cycle after `stall` drops.
- Redirect to 0x203 → fetch at 0x200; `misalign_err`=1 and stays 1 until reset.
- PC 0xFFFF_FFFC fetched → next request address is 0x0000_0000; `rst_n` pulse mid-WAIT → state FETCH at `RESET_PC`, `if_id_valid`=0.
